issue_buffer: RTL

Decoded-instruction FIFO between the issue manager and the CSU. It captures every instruction the issue manager presents on its registered issue bus and holds it until the CSU accepts it. It returns `issue_space_available` to the issue manager with enough slack to absorb instructions already in flight. A pipeline flush empties the buffer.

---
 rtl/issue_buffer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/issue_buffer.sv
// Decoded-instruction FIFO between the issue manager and the CSU.
// First-word-fall-through output, early space feedback, sticky overflow flag and flush.
module issue_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SLACK = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_pipline,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_pred_pc,
  input  logic [31:0]              in_full_ins,
  input  logic [31:0]              in_imm,
  input  logic [6:0]               in_opcode,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [5:0]               in_shamt,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [4:0]               in_rd,
  input  logic                     in_compressed,
  output logic                     issue_space_available,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_pred_pc,
  output logic [31:0]              out_full_ins,
  output logic [31:0]              out_imm,
  output logic [6:0]               out_opcode,
  output logic [2:0]               out_funct3,
  output logic [6:0]               out_funct7,
  output logic [5:0]               out_shamt,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic                     out_compressed,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DepthW = (PW+1)'(DEPTH);
  localparam logic [PW:0] SlackW = (PW+1)'(SLACK);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pred_pc;
    logic [31:0] full_ins;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [5:0]  shamt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        compressed;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic [PW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full, push, pop;

  assign full = (count_q == DepthW);
  assign pop  = rdy_in & (count_q != '0) & out_ready & ~flush_pipline;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign push = rdy_in & in_valid & ~flush_pipline & (~full | pop);

  always_comb begin
    rp_d       = rp_q;
    wp_d       = wp_q;
    count_d    = count_q;
    overflow_d = overflow_q | (rdy_in & in_valid & ~flush_pipline & full & ~pop);
    if (rdy_in) begin
      if (flush_pipline) begin
        rp_d    = '0;
        wp_d    = '0;
        count_d = '0;
      end else begin
        if (push) wp_d = wp_q + 1'b1;
        if (pop)  rp_d = rp_q + 1'b1;
        unique case ({push, pop})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rp_q       <= '0;
      wp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rp_q       <= rp_d;
      wp_q       <= wp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    wr_entry = '{pc: in_pc, pred_pc: in_pred_pc, full_ins: in_full_ins, imm: in_imm,
                 opcode: in_opcode, funct3: in_funct3, funct7: in_funct7, shamt: in_shamt,
                 rs1: in_rs1, rs2: in_rs2, rd: in_rd, compressed: in_compressed};
  end

  // Storage is deliberately not reset; contents are only meaningful below count.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wp_q] <= wr_entry;
  end

  assign head = mem_q[rp_q];

  assign out_pc         = head.pc;
  assign out_pred_pc    = head.pred_pc;
  assign out_full_ins   = head.full_ins;
  assign out_imm        = head.imm;
  assign out_opcode     = head.opcode;
  assign out_funct3     = head.funct3;
  assign out_funct7     = head.funct7;
  assign out_shamt      = head.shamt;
  assign out_rs1        = head.rs1;
  assign out_rs2        = head.rs2;
  assign out_rd         = head.rd;
  assign out_compressed = head.compressed;

  assign out_valid             = (count_q != '0);
  assign count                 = count_q;
  assign overflow_err          = overflow_q;
  assign issue_space_available = ((DepthW - count_q) >= SlackW);

endmodule
